apb4_mem_slave: RTL and testbench
=================================

# apb4_mem_slave

APB4 completer with byte-addressable word memory and a programmable wait-state count; one instance sits on each PSELx output of the APB4 requester bridge. It accepts SETUP/ACCESS transfers, inserts a fixed number of wait states, and applies PSTRB byte lanes on writes. It drives PREADY, PRDATA and PSLVERR back to the bridge, and flags out-of-range or misaligned accesses with PSLVERR.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
- ADDR_WIDTH, 32, PADDR width
- MEM_DEPTH, 64, number of DATA_WIDTH words
- WAIT_CYCLES, 1, wait states inserted before PREADY (0..15)
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset; synchronous, active-low
- PSEL  in  1  slave select from bridge
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte lanes
- PPROT  in  3  protection attributes
- PREADY  out  1  transfer completion, registered
- PRDATA  out  DATA_WIDTH  read data, registered
- PSLVERR  out  1  error response, registered, valid only with PREADY

## Operation
- Offset = PADDR[ADDR_WIDTH-2:2]. PADDR[ADDR_WIDTH-1] is the bridge's slave-select bit and is ignored.
- err = (offset >= MEM_DEPTH) || (PADDR[1:0] != 0).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on PSEL && !PENABLE:
    - WAIT_CYCLES == 0: go to RESP.
    - Otherwise: go to WAIT, loading cnt = WAIT_CYCLES-1.
  - WAIT: if !PSEL, go to IDLE (abort, no write). Else if cnt == 0, go to RESP. Else decrement cnt.
  - RESP: PREADY = 1 for exactly one cycle. At the edge ending RESP, go to IDLE and drive PREADY = 0, PSLVERR = 0.
- Entry to RESP registers the response:
  - PSLVERR = err.
  - PRDATA = mem[offset] for a read with !err; otherwise 0.
- Write commit happens at the edge ending RESP, when PSEL && PENABLE && PWRITE && !err. Lane i is written iff PSTRB[i]. PSTRB = 0 completes with no change.
- Reads ignore PSTRB.
- PRDATA holds its value after RESP until the next read response.
- Memory contents are not affected by reset.

## Timing
- Reset values: PREADY = 0, PRDATA = 0, PSLVERR = 0, state IDLE, cnt = 0.
- Transfer length: setup cycle + (WAIT_CYCLES+1) access cycles. PREADY is high in the last access cycle.
- Back-to-back transfers: a new setup in the cycle after RESP is accepted from IDLE with no bubble.
- A read immediately after a write to the same offset returns the new data.
- PSEL dropping in WAIT or RESP (bridge violation): return to IDLE, no write, PREADY = 0 next cycle.
- Reset asserted mid-transfer: all outputs are zero at the next edge and any pending write is discarded.
- A PENABLE high seen in IDLE without a prior setup is ignored.

## Configuration
- APB4_SLV_PPROT_EN defined: a write with PPROT[0] == 0 (unprivileged) is treated as err. It gets PSLVERR = 1 and no memory update. Reads are unaffected.
- Not defined: PPROT is ignored and has no effect on responses.

## Structure
- Package apb4_pkg holds:
  - state enum apb4_slv_state_e {IDLE, WAIT, RESP}
  - default-width localparams
  - cnt width constant (4 bits)
- Sub-module apb4_slv_mem: MEM_DEPTH x DATA_WIDTH array with a byte-enable synchronous write port and a read port addressed by offset.
- The top holds the FSM, wait counter, decode and response registers.

## Test plan
All scenarios use default parameters unless stated.
- Reset: hold PRESETn = 0 for 2 cycles → PREADY = 0, PRDATA = 0, PSLVERR = 0 at the first edge after assertion.
- Full write then read: write PADDR = 0x0000_0010, PWDATA = 0xDEAD_BEEF, PSTRB = 4'hF → PREADY high in the 2nd access cycle, PSLVERR = 0. Read back at 0x10 → PRDATA = 0xDEAD_BEEF.
- Byte-lane write: write 0x11223344 with PSTRB = 4'b0101 over 0xDEAD_BEEF → read returns 0xDE22_BE44.
- Out-of-range read: read PADDR = 0x0000_0100 (offset 64) → PSLVERR = 1 and PRDATA = 0 with PREADY. A read at 0x8000_0010 returns the offset-4 data.
- Zero-wait and abort:
  - WAIT_CYCLES = 0: PREADY is high in the first access cycle.
  - WAIT_CYCLES = 3: deassert PSEL in the 2nd wait cycle → no write, FSM in IDLE, PREADY never asserted.
- Macro enabled: write with PPROT = 3'b000 → PSLVERR = 1, memory unchanged. Write with PPROT = 3'b001 → success.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared types and default sizes for the APB4 memory completer.
package apb4_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 64;
    localparam int DEF_WAIT_CYCLES = 1;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb4_slv_state_e;

endpackage

// File: rtl/apb4_slv_mem.sv
// Word-organised storage with a byte-enable synchronous write port and a
// combinational read port sharing one word address.
module apb4_slv_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_W      = 6
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Byte-lane write; lanes with a clear strobe keep their old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer backed by a word memory, with a fixed number of wait
// states before PREADY. Out-of-range or misaligned accesses get PSLVERR.
// Optional: define APB4_SLV_PPROT_EN to reject unprivileged writes
// (PPROT[0] == 0) with PSLVERR and no memory update.
module apb4_mem_slave
    import apb4_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int OFF_W = ADDR_WIDTH - 3;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    apb4_slv_state_e       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [OFF_W-1:0]      off_c;
    logic                  err_c;
    logic                  go_resp_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] mem_rdata_c;
    logic                  unused_c;

    // Top address bit is the bridge's select bit, so it is dropped here.
    assign off_c = PADDR[ADDR_WIDTH-2:2];

    // Bits not needed by the decode in every build.
    assign unused_c = ^{PPROT, PADDR[ADDR_WIDTH-1]};

    // Access decode: range and alignment, plus privilege when enabled.
    always_comb begin
        err_c = (off_c >= OFF_W'(MEM_DEPTH)) || (PADDR[1:0] != 2'b00);
`ifdef APB4_SLV_PPROT_EN
        if (PWRITE && !PPROT[0]) begin
            err_c = 1'b1;
        end
`else
`endif
    end

    // Commit lands on the edge that ends RESP; a reset on that edge wins.
    assign mem_we_c = (state_q == RESP) && PSEL && PENABLE && PWRITE &&
                      !err_c && PRESETn;

    apb4_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i   (PCLK),
        .we_i    (mem_we_c),
        .addr_i  (off_c[IDX_W-1:0]),
        .wdata_i (PWDATA),
        .wstrb_i (PSTRB),
        .rdata_o (mem_rdata_c)
    );

    // Next-state, wait counter and response capture on entry to RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        go_resp_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (WAIT_CYCLES == 0) begin
                        go_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    go_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_resp_c) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = err_c;
            // PRDATA only changes on read responses; writes leave it alone.
            if (!PWRITE) begin
                prdata_d = err_c ? '0 : mem_rdata_c;
            end
        end
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: three instances with 1, 0 and 3 wait
// states share the bus wires; each has its own PSEL.
module tb_apb4_mem_slave;

    localparam int NDUT = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NDUT-1:0] psel;
    logic            penable, pwrite;
    logic [31:0]     paddr, pwdata;
    logic [3:0]      pstrb;
    logic [2:0]      pprot;
    logic [NDUT-1:0] pready, pslverr;
    logic [31:0]     prdata [NDUT];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb4_mem_slave #(.WAIT_CYCLES(1)) u_dut0 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PREADY(pready[0]), .PRDATA(prdata[0]),
        .PSLVERR(pslverr[0])
    );

    apb4_mem_slave #(.WAIT_CYCLES(0)) u_dut1 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PREADY(pready[1]), .PRDATA(prdata[1]),
        .PSLVERR(pslverr[1])
    );

    apb4_mem_slave #(.WAIT_CYCLES(3)) u_dut2 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PREADY(pready[2]), .PRDATA(prdata[2]),
        .PSLVERR(pslverr[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transfer on instance k; n counts access cycles up to PREADY.
    task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, output logic [31:0] rd,
                        output logic er, output int n);
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        pprot   = p;
        tick;
        penable = 1'b1;
        n = 1;
        while (pready[k] !== 1'b1 && n < 32) begin
            tick;
            n++;
        end
        if (pready[k] !== 1'b1) chk("timeout", {31'd0, pready[k]}, 32'd1);
        rd = prdata[k];
        er = pslverr[k];
        tick;
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic do_wr(input string tag, input int k, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input int ecyc, input logic eerr);
        logic [31:0] rd;
        logic        er;
        int          n;
        xfer(k, 1'b1, a, d, s, p, rd, er, n);
        chk({tag, "_cyc"}, n, ecyc);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, eerr});
    endtask

    task automatic do_rd(input string tag, input int k, input logic [31:0] a,
                         input logic [31:0] edata, input int ecyc, input logic eerr);
        logic [31:0] rd;
        logic        er;
        int          n;
        xfer(k, 1'b0, a, 32'h0, 4'h0, 3'b001, rd, er, n);
        chk({tag, "_cyc"},  n, ecyc);
        chk({tag, "_err"},  {31'd0, er}, {31'd0, eerr});
        chk({tag, "_data"}, rd, edata);
    endtask

    initial begin
        rstn    = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = 3'b001;

        // Reset held two cycles; outputs zero after the first edge.
        tick;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_pready",  {31'd0, pready[k]},  32'd0);
            chk("rst_pslverr", {31'd0, pslverr[k]}, 32'd0);
            chk("rst_prdata",  prdata[k], 32'd0);
        end
        tick;
        rstn = 1'b1;
        tick;

        // One wait state: PREADY in the 2nd access cycle.
        do_wr("wr_full",  0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b001, 2, 1'b0);
        do_rd("rd_full",  0, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0);
        do_wr("wr_lanes", 0, 32'h0000_0010, 32'h1122_3344, 4'b0101, 3'b001, 2, 1'b0);
        do_rd("rd_lanes", 0, 32'h0000_0010, 32'hDE22_BE44, 2, 1'b0);
        do_rd("rd_oor",   0, 32'h0000_0100, 32'h0, 2, 1'b1);
        do_rd("rd_selb",  0, 32'h8000_0010, 32'hDE22_BE44, 2, 1'b0);
        do_rd("rd_misal", 0, 32'h0000_0012, 32'h0, 2, 1'b1);
        do_wr("wr_strb0", 0, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 3'b001, 2, 1'b0);
        do_rd("rd_strb0", 0, 32'h0000_0010, 32'hDE22_BE44, 2, 1'b0);
        tick;
        chk("prdata_hold", prdata[0], 32'hDE22_BE44);

        // PENABLE without a setup phase must not start a transfer.
        psel[0] = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("no_setup_pready", {31'd0, pready[0]}, 32'd0);
        end
        psel    = '0;
        penable = 1'b0;
        tick;

        // Reset during RESP discards the pending write and clears outputs.
        psel[0] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0000_0010;
        pwdata  = 32'hAAAA_AAAA;
        pstrb   = 4'hF;
        tick;
        penable = 1'b1;
        tick;
        chk("mid_pready_pre", {31'd0, pready[0]}, 32'd1);
        rstn = 1'b0;
        tick;
        chk("mid_rst_pready",  {31'd0, pready[0]},  32'd0);
        chk("mid_rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
        chk("mid_rst_prdata",  prdata[0], 32'd0);
        rstn    = 1'b1;
        psel    = '0;
        penable = 1'b0;
        tick;
        do_rd("rd_after_rst", 0, 32'h0000_0010, 32'hDE22_BE44, 2, 1'b0);

        // Privilege attribute on writes.
        do_wr("wr_priv", 0, 32'h0000_0018, 32'h55AA_55AA, 4'hF, 3'b001, 2, 1'b0);
`ifdef APB4_SLV_PPROT_EN
        do_wr("wr_unpriv", 0, 32'h0000_0018, 32'h0000_0000, 4'hF, 3'b000, 2, 1'b1);
        do_rd("rd_unpriv", 0, 32'h0000_0018, 32'h55AA_55AA, 2, 1'b0);
`else
        do_wr("wr_unpriv", 0, 32'h0000_0018, 32'h0000_0000, 4'hF, 3'b000, 2, 1'b0);
        do_rd("rd_unpriv", 0, 32'h0000_0018, 32'h0000_0000, 2, 1'b0);
`endif

        // Zero wait states, back-to-back write then read.
        do_wr("z_wr", 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 3'b001, 1, 1'b0);
        do_rd("z_rd", 1, 32'h0000_0020, 32'hCAFE_F00D, 1, 1'b0);
        do_rd("z_oor", 1, 32'h0000_0400, 32'h0, 1, 1'b1);

        // Three wait states, then an abort in the 2nd wait cycle.
        do_wr("w3_wr", 2, 32'h0000_0008, 32'h1234_5678, 4'hF, 3'b001, 4, 1'b0);
        psel[2] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0000_0008;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        tick;
        penable = 1'b1;
        chk("abort_a1", {31'd0, pready[2]}, 32'd0);
        tick;
        chk("abort_a2", {31'd0, pready[2]}, 32'd0);
        psel    = '0;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort_idle", {31'd0, pready[2]}, 32'd0);
        end
        do_rd("abort_rd", 2, 32'h0000_0008, 32'h1234_5678, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
